// File: rtl/rr_grant_arbiter8.sv
// rr_grant_arbiter8 -- eight-requester round-robin arbiter with held grants.
//
// A grant is held until the owner releases it. The owner releases it by
// pulsing done or by dropping its request line. The next search then starts
// one past the previous owner. Every output is driven straight from a flop.
// Each change of owner is separated by one dead (no-grant) cycle.
//
// Optional feature: define ARB_TIMEOUT_EN to build a grant watchdog. The
// watchdog forces a release after TIMEOUT grant cycles and pulses timeout.
// When ARB_TIMEOUT_EN is undefined, timeout is tied low.
//
// Parameters
//   TIMEOUT   watchdog limit in cycles (2..255), used only with ARB_TIMEOUT_EN
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   req[7:0]  request lines, held by each requester until served
//   done      release strobe from the current owner (ignored when idle)
//   gnt_idx   index of the current/last owner
//   gnt_valid a grant is active
//   gnt[7:0]  one-hot grant, zero when gnt_valid=0
//   timeout   one-cycle pulse on a watchdog-forced release
module rr_grant_arbiter8 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic [7:0] gnt,
  output logic       timeout
);

  generate
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("rr_grant_arbiter8: TIMEOUT out of range 2..255");
    end
  endgenerate

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;

  // Rotate the requests so that ptr lands on bit 0. A plain lowest-set-bit
  // search then gives the offset from ptr, and adding ptr back gives the
  // winning index. The 3-bit add wraps the index modulo 8.
  logic [15:0] req2;
  logic [7:0]  rot;
  logic [2:0]  off;
  logic        hit;
  logic [2:0]  sel;
  logic        rel;

  always_comb begin
    req2 = {req, req};
    rot  = 8'(req2 >> ptr);
    off  = 3'd0;
    hit  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        off = 3'(i);
        hit = 1'b1;
      end
    end
    sel = ptr + off;
    // Either cause releases the grant; when both occur together, they
    // count as a single release.
    rel = done | ~req[gnt_idx];
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      gnt       <= 8'h00;
`ifdef ARB_TIMEOUT_EN
      wd_cnt    <= 8'd0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (hit) begin
            state     <= GRANT;
            gnt_idx   <= sel;
            gnt_valid <= 1'b1;
            gnt       <= 8'b1 << sel;
`ifdef ARB_TIMEOUT_EN
            wd_cnt    <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (rel) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt       <= 8'h00;
            ptr       <= gnt_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
          end else if (wd_cnt == WD_LAST) begin
            // A forced release has the same effect as a normal release,
            // including the pointer advance, and it flags the event.
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt       <= 8'h00;
            ptr       <= gnt_idx + 3'd1;
            timeout   <= 1'b1;
          end else begin
            wd_cnt    <= wd_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
module tb_rr_grant_arbiter8;

  localparam int TO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [7:0] gnt;
  logic       timeout;

  rr_grant_arbiter8 #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .gnt(gnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic       v;
    logic [7:0] g;
    logic       to;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   running = 1'b0;

  // Reference model: who owns the resource, where the next search starts,
  // and how long the current owner has held it.
  bit m_busy = 0;
  int m_own  = 0;
  int m_ptr  = 0;
  int m_age  = 0;
  bit m_to   = 0;

  task automatic model_step();
    exp_t e;
    if (rst) begin
      m_busy = 0; m_own = 0; m_ptr = 0; m_age = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 0; k < 8; k++) begin
        if (req[(m_ptr + k) % 8]) begin
          m_own  = (m_ptr + k) % 8;
          m_busy = 1;
          m_age  = 0;
          break;
        end
      end
    end else if (done || !req[m_own]) begin
      m_busy = 0; m_ptr = (m_own + 1) % 8; m_to = 0;
    end else if (WD && m_age == TO - 1) begin
      m_busy = 0; m_ptr = (m_own + 1) % 8; m_to = 1;
    end else begin
      m_age++;
      m_to = 0;
    end
    e.idx = 3'(m_own);
    e.v   = m_busy;
    e.g   = m_busy ? 8'(1 << m_own) : 8'h00;
    e.to  = m_to;
    q.push_back(e);
    running = 1'b1;
  endtask

  task automatic drive(input bit r, input logic [7:0] rq, input bit d);
    @(negedge clk);
    rst = r; req = rq; done = d;
    model_step();
  endtask

  // Monitor: the DUT presents a full output set after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
        end else begin
          e = q.pop_front();
          if (gnt_idx !== e.idx || gnt_valid !== e.v || gnt !== e.g || timeout !== e.to) begin
            miscompares++;
            $display("FAIL outputs t=%0t: got idx=%0d v=%0b gnt=%h to=%0b, want idx=%0d v=%0b gnt=%h to=%0b",
                     $time, gnt_idx, gnt_valid, gnt, timeout, e.idx, e.v, e.g, e.to);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    // reset state
    drive(1, 8'h00, 0);
    drive(1, 8'hFF, 1);
    drive(0, 8'h00, 1);
    // reset mid-grant: own idx 5, reset, then 0xFF grants idx 0
    drive(0, 8'h20, 0);
    drive(0, 8'h20, 0);
    drive(1, 8'h20, 0);
    drive(0, 8'hFF, 0);
    drive(0, 8'hFF, 1);
    // round-robin wrap 0..7,0
    drive(1, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 8'hFF, 0);
      drive(0, 8'hFF, 1);
    end
    // pointer skip: release 6, then 0x21 -> 0, then 5
    drive(1, 8'h00, 0);
    drive(0, 8'h40, 0);
    drive(0, 8'h40, 1);
    drive(0, 8'h21, 0);
    drive(0, 8'h21, 1);
    drive(0, 8'h21, 0);
    drive(0, 8'h21, 1);
    // simultaneous done + request drop
    drive(1, 8'h00, 0);
    drive(0, 8'h02, 0);
    drive(0, 8'h00, 1);
    drive(0, 8'hFF, 0);
    drive(0, 8'hFF, 1);
    // preemption blocked
    drive(1, 8'h00, 0);
    drive(0, 8'h04, 0);
    for (int i = 0; i < 3; i++) drive(0, 8'h84, 0);
    drive(0, 8'h84, 1);
    drive(0, 8'h80, 0);
    drive(0, 8'h80, 0);
    drive(0, 8'h80, 1);
    // watchdog / indefinite hold
    drive(1, 8'h00, 0);
    drive(0, 8'h08, 0);
    for (int i = 0; i < 17; i++) drive(0, 8'h08, 0);
    for (int i = 0; i < 110; i++) drive(0, 8'h18, 0);
    // randomized traffic
    drive(1, 8'h00, 0);
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r = 8'($urandom);
      else r = r | (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      drive(($urandom_range(0, 99) == 0), r, ($urandom_range(0, 5) == 0));
      if (gnt_valid && done && $urandom_range(0, 1) == 0) r[gnt_idx] = 1'b0;
    end
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
